// File: rtl/instr_prefetch_buf.sv
// Sequential instruction prefetcher: issues word reads, buffers returns in a
// small FIFO and hands them to fetch over valid/ready, flushing on redirect.
module instr_prefetch_buf #(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = 18'h20080
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en_i,
    input  logic                  branch_i,
    input  logic [ADDR_WIDTH-1:0] branch_addr_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_ready_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        IDLE,
        FETCH
    } state_e;

    state_e state_q;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] iss_addr_q;
    logic [ADDR_WIDTH-1:0] tgt;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic                  inflight_q;
    logic                  discard_q;

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] tag_q  [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_hold_q;
    logic [ADDR_WIDTH-1:0] addr_hold_q;

    logic active;
    logic slot_ok;
    logic not_empty;
    logic push;
    logic pop;

    assign tgt       = branch_addr_i & ~ADDR_WIDTH'(3);
    assign active    = (state_q == FETCH) || fetch_en_i;
    // Occupancy plus the outstanding read; a same-cycle pop earns no credit.
    assign slot_ok   = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q})
                       < (CW+1)'(DEPTH);
    assign mem_en_o  = !rst && (branch_i ? fetch_en_i : (active && slot_ok));
    assign mem_addr_o = branch_i ? tgt : pc_q;

    assign not_empty     = (count_q != '0);
    assign instr_valid_o = not_empty && !branch_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign push          = inflight_q && !discard_q && !branch_i;

    // Once empty the head outputs freeze on the last word presented.
    assign instr_rdata_o = not_empty ? data_q[rd_ptr_q] : rdata_hold_q;
    assign instr_addr_o  = not_empty ? tag_q[rd_ptr_q]  : addr_hold_q;

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (branch_i) begin
            pc_d     = mem_en_o ? tgt + ADDR_WIDTH'(4) : tgt;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (mem_en_o) begin
                pc_d = pc_q + ADDR_WIDTH'(4);
            end
            count_d  = count_q + CW'(push) - CW'(pop);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= BOOT_ADDR;
            iss_addr_q   <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            inflight_q   <= 1'b0;
            discard_q    <= 1'b0;
            rdata_hold_q <= '0;
            addr_hold_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch_en_i) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (!fetch_en_i && !branch_i) begin
                        state_q <= IDLE;
                    end
                end
            endcase
            pc_q       <= pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= mem_en_o;
            discard_q  <= branch_i && !mem_en_o;
            if (mem_en_o) begin
                iss_addr_q <= mem_addr_o;
            end
            if (not_empty) begin
                rdata_hold_q <= data_q[rd_ptr_q];
                addr_hold_q  <= tag_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            data_q[wr_ptr_q] <= mem_rdata_i;
            tag_q[wr_ptr_q]  <= iss_addr_q;
        end
    end

    count_bound_a : assert property (
        @(posedge clk) disable iff (rst) count_q <= CW'(DEPTH)
    );

endmodule
